// File: rtl/exe_mem_issue.sv
// Execute-stage memory issue: latches load/store instructions from ID, computes the
// effective address and alignment exception, drives the data-SRAM request handshake and
// remembers how many accepted requests were cancelled by a flush so MEM can drop their
// responses.
module exe_mem_issue #(
  parameter int unsigned DISCARD_W = 2
) (
  input  logic        clk,
  input  logic        resetn,
  // ID -> EXE
  input  logic        ds_to_es_valid,
  output logic        es_allowin,
  input  logic [7:0]  ds_op,
  input  logic [31:0] ds_base,
  input  logic [31:0] ds_offset,
  input  logic [31:0] ds_st_data,
  input  logic [4:0]  ds_dest,
  input  logic [31:0] ds_pc,
  input  logic        ds_ex,
  // EXE -> MEM
  input  logic        ms_allowin,
  input  logic        ms_ex,
  input  logic        flush,
  output logic        es_to_ms_valid,
  output logic [77:0] es_to_ms_bus,
  // Data SRAM request channel
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [1:0]  data_sram_size,
  output logic [3:0]  data_sram_wstrb,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic        data_sram_addr_ok,
  input  logic        data_sram_data_ok,
  output logic        discard_pending
);

  typedef enum logic [1:0] {
    StIdle,      // no request outstanding for the held instruction
    StWaitAddr,  // request raised, waiting for addr_ok
    StSent,      // address accepted, instruction not yet handed to MEM
    StOrphan     // request raised but its instruction was flushed
  } state_e;

  localparam logic [DISCARD_W-1:0] DiscardMax = {DISCARD_W{1'b1}};

  state_e               state_q, state_d;
  logic                 es_valid_q, es_valid_d;
  logic [DISCARD_W-1:0] discard_q, discard_d;

  // Latched instruction fields
  logic [7:0]  op_q;
  logic [31:0] base_q;
  logic [31:0] offset_q;
  logic [31:0] st_data_q;
  logic [4:0]  dest_q;
  logic [31:0] pc_q;
  logic        ex_q;

  // Decode signals
  logic        ld_b, ld_bu, ld_h, ld_hu, ld_w, st_b, st_h, st_w;
  logic        op_half, op_word;
  logic        mem_re, mem_we, is_mem;
  logic [31:0] addr;
  logic        ale, ex_any;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] wdata;

  // Handshake signals
  logic req;
  logic ready_go;
  logic leave;
  logic capture;
  logic disc_inc, disc_dec;

  assign {ld_b, ld_bu, ld_h, ld_hu, ld_w, st_b, st_h, st_w} = op_q;

  assign op_half = ld_h | ld_hu | st_h;
  assign op_word = ld_w | st_w;
  assign mem_re  = ld_b | ld_bu | ld_h | ld_hu | ld_w;
  assign mem_we  = st_b | st_h | st_w;
  assign is_mem  = mem_re | mem_we;

  assign addr   = base_q + offset_q;
  assign ale    = (op_half && addr[0]) || (op_word && (addr[1:0] != 2'b00));
  assign ex_any = ex_q || ale;

  // Access size, byte enables and lane-replicated store data from the latched op
  always_comb begin
    size  = 2'd0;
    wstrb = 4'b0000;
    wdata = 32'h0;
    if (op_word) begin
      size = 2'd2;
    end else if (op_half) begin
      size = 2'd1;
    end
    if (st_b) begin
      wstrb = 4'b0001 << addr[1:0];
      wdata = {4{st_data_q[7:0]}};
    end else if (st_h) begin
      wstrb = addr[1] ? 4'b1100 : 4'b0011;
      wdata = {2{st_data_q[15:0]}};
    end else if (st_w) begin
      wstrb = 4'b1111;
      wdata = st_data_q;
    end
  end

  // Request generation: once raised, a request stays up until addr_ok, even if flushed
  always_comb begin
    req = 1'b0;
    case (state_q)
      StIdle:     req = es_valid_q && is_mem && !ex_any && !ms_ex && !flush;
      StWaitAddr: req = 1'b1;
      StOrphan:   req = 1'b1;
      default:    req = 1'b0;
    endcase
  end

  assign ready_go = !is_mem || ex_any || (state_q == StSent) ||
                    (req && data_sram_addr_ok && (state_q != StOrphan));

  assign es_to_ms_valid = es_valid_q && ready_go;
  assign leave          = es_to_ms_valid && ms_allowin;
  // Gated by resetn so every output reads zero while reset is held
  assign es_allowin     = resetn && (state_q != StOrphan) &&
                          (!es_valid_q || (ready_go && ms_allowin));
  assign capture        = ds_to_es_valid && es_allowin && !flush;

  // Next-state logic for the request FSM and flush-cancel detection
  always_comb begin
    state_d  = state_q;
    disc_inc = 1'b0;
    case (state_q)
      StIdle: begin
        if (req) begin
          if (!data_sram_addr_ok) begin
            state_d = StWaitAddr;
          end else if (!leave) begin
            state_d = StSent;
          end
        end
      end
      StWaitAddr: begin
        if (data_sram_addr_ok) begin
          disc_inc = flush;
          state_d  = (flush || leave) ? StIdle : StSent;
        end else if (flush) begin
          state_d = StOrphan;
        end
      end
      StSent: begin
        if (flush) begin
          disc_inc = 1'b1;
          state_d  = StIdle;
        end else if (leave) begin
          state_d = StIdle;
        end
      end
      StOrphan: begin
        if (data_sram_addr_ok) begin
          disc_inc = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Stage valid: flush wins over capture, capture wins over hand-off
  always_comb begin
    es_valid_d = es_valid_q;
    if (flush) begin
      es_valid_d = 1'b0;
    end else if (capture) begin
      es_valid_d = 1'b1;
    end else if (leave) begin
      es_valid_d = 1'b0;
    end
  end

  // Cancelled-request counter: saturating, simultaneous inc/dec cancel out
  always_comb begin
    disc_dec  = data_sram_data_ok && (discard_q != '0);
    discard_d = discard_q;
    if (disc_inc && !disc_dec) begin
      if (discard_q != DiscardMax) begin
        discard_d = discard_q + DISCARD_W'(1);
      end
    end else if (disc_dec && !disc_inc) begin
      discard_d = discard_q - DISCARD_W'(1);
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      es_valid_q <= 1'b0;
      discard_q  <= '0;
    end else begin
      state_q    <= state_d;
      es_valid_q <= es_valid_d;
      discard_q  <= discard_d;
    end
  end

  // Instruction payload registers, loaded only on capture so an orphan request stays stable
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_q      <= 8'h0;
      base_q    <= 32'h0;
      offset_q  <= 32'h0;
      st_data_q <= 32'h0;
      dest_q    <= 5'h0;
      pc_q      <= 32'h0;
      ex_q      <= 1'b0;
    end else if (capture) begin
      op_q      <= ds_op;
      base_q    <= ds_base;
      offset_q  <= ds_offset;
      st_data_q <= ds_st_data;
      dest_q    <= ds_dest;
      pc_q      <= ds_pc;
      ex_q      <= ds_ex;
    end
  end

  assign data_sram_req   = req;
  assign data_sram_wr    = mem_we;
  assign data_sram_size  = size;
  assign data_sram_wstrb = wstrb;
  assign data_sram_addr  = addr;
  assign data_sram_wdata = wdata;
  assign discard_pending = (discard_q != '0);

  assign es_to_ms_bus = {mem_re, mem_we, ex_any, ale, op_q[7:3], dest_q, addr, pc_q};

endmodule

// File: tb/tb_exe_mem_issue.sv
// Self-checking bench for exe_mem_issue: decode table, directed handshake sequences and a
// randomized run compared against a transaction-level reference model.
module tb_exe_mem_issue;

  localparam int unsigned DW = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ds_to_es_valid;
  logic        es_allowin;
  logic [7:0]  ds_op;
  logic [31:0] ds_base, ds_offset, ds_st_data, ds_pc;
  logic [4:0]  ds_dest;
  logic        ds_ex;
  logic        ms_allowin, ms_ex, flush;
  logic        es_to_ms_valid;
  logic [77:0] es_to_ms_bus;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic        discard_pending;

  always #5 clk = ~clk;

  exe_mem_issue #(.DISCARD_W(DW)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .ds_to_es_valid    (ds_to_es_valid),
    .es_allowin        (es_allowin),
    .ds_op             (ds_op),
    .ds_base           (ds_base),
    .ds_offset         (ds_offset),
    .ds_st_data        (ds_st_data),
    .ds_dest           (ds_dest),
    .ds_pc             (ds_pc),
    .ds_ex             (ds_ex),
    .ms_allowin        (ms_allowin),
    .ms_ex             (ms_ex),
    .flush             (flush),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .data_sram_req     (data_sram_req),
    .data_sram_wr      (data_sram_wr),
    .data_sram_size    (data_sram_size),
    .data_sram_wstrb   (data_sram_wstrb),
    .data_sram_addr    (data_sram_addr),
    .data_sram_wdata   (data_sram_wdata),
    .data_sram_addr_ok (data_sram_addr_ok),
    .data_sram_data_ok (data_sram_data_ok),
    .discard_pending   (discard_pending)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- decode table ----------------
  typedef struct {
    logic [7:0]  op;
    logic [31:0] base;
    logic [31:0] off;
    logic [31:0] data;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  flags;  // {mem_re, mem_we, ex_any, ale}
  } vec_t;

  vec_t vecs[10];

  // ---------------- reference model ----------------
  logic [7:0]  m_op;
  logic [31:0] m_base, m_off, m_data, m_pc;
  logic [4:0]  m_dest;
  logic        m_ex;
  bit          m_valid, m_issued, m_waiting, m_orphan;
  int          m_disc;

  logic        e_load, e_store, e_ale, e_exany, e_req, e_rg, e_ov, e_allow;
  logic [1:0]  e_size;
  logic [3:0]  e_wstrb;
  logic [31:0] e_addr, e_wdata;
  logic [77:0] e_bus;

  task automatic model_reset();
    m_op = 0; m_base = 0; m_off = 0; m_data = 0; m_pc = 0; m_dest = 0; m_ex = 0;
    m_valid = 0; m_issued = 0; m_waiting = 0; m_orphan = 0; m_disc = 0;
  endtask

  // Outputs implied by the held instruction and current inputs
  task automatic model_eval();
    int unsigned w, lo, sh;
    e_addr  = m_base + m_off;
    e_load  = |m_op[7:3];
    e_store = |m_op[2:0];
    if (m_op[7] | m_op[6] | m_op[2])      w = 1;
    else if (m_op[5] | m_op[4] | m_op[1]) w = 2;
    else if (m_op[3] | m_op[0])           w = 4;
    else                                  w = 0;
    lo      = e_addr % 4;
    e_ale   = (w > 1) && ((e_addr % w) != 0);
    e_exany = m_ex || e_ale;
    e_size  = (w == 4) ? 2'd2 : (w == 2) ? 2'd1 : 2'd0;
    e_wstrb = 4'h0;
    e_wdata = 32'h0;
    if (e_store) begin
      sh      = lo - (lo % w);
      e_wstrb = 4'(((1 << w) - 1) << sh);
      if (w == 1)      e_wdata = {24'h0, m_data[7:0]} * 32'h01010101;
      else if (w == 2) e_wdata = {16'h0, m_data[15:0]} * 32'h00010001;
      else             e_wdata = m_data;
    end
    e_bus   = {e_load, e_store, e_exany, e_ale, m_op[7:3], m_dest, e_addr, m_pc};
    e_req   = m_waiting || m_orphan ||
              (m_valid && !m_issued && (e_load || e_store) && !e_exany && !ms_ex && !flush);
    e_rg    = !(e_load || e_store) || e_exany || m_issued ||
              (e_req && data_sram_addr_ok && !m_orphan);
    e_ov    = m_valid && e_rg;
    e_allow = !m_orphan && (!m_valid || (e_rg && ms_allowin));
  endtask

  // Advance the model across one clock edge using the inputs seen before it
  task automatic model_step();
    bit leave, inc, dec, cap;
    leave = e_ov && ms_allowin;
    inc   = 0;
    cap   = ds_to_es_valid && e_allow && !flush;
    if (m_orphan) begin
      if (data_sram_addr_ok) begin m_orphan = 0; inc = 1; end
    end else if (m_waiting) begin
      if (data_sram_addr_ok) begin
        m_waiting = 0;
        if (flush) inc = 1;
        else       m_issued = !leave;
      end else if (flush) begin
        m_waiting = 0;
        m_orphan  = 1;
      end
    end else if (m_issued) begin
      if (flush) begin inc = 1; m_issued = 0; end
      else if (leave) m_issued = 0;
    end else if (e_req) begin
      if (data_sram_addr_ok) m_issued = !leave;
      else                   m_waiting = 1;
    end
    dec = data_sram_data_ok && (m_disc > 0);
    if (inc && !dec)      m_disc = (m_disc < (1 << DW) - 1) ? m_disc + 1 : m_disc;
    else if (dec && !inc) m_disc = m_disc - 1;
    if (flush) m_valid = 0;
    else if (cap) begin
      m_valid = 1;
      m_op = ds_op; m_base = ds_base; m_off = ds_offset; m_data = ds_st_data;
      m_dest = ds_dest; m_pc = ds_pc; m_ex = ds_ex;
    end else if (leave) m_valid = 0;
  endtask

  task automatic idle_inputs();
    ds_to_es_valid = 0; ds_op = 0; ds_base = 0; ds_offset = 0; ds_st_data = 0;
    ds_dest = 0; ds_pc = 0; ds_ex = 0; ms_allowin = 1; ms_ex = 0; flush = 0;
    data_sram_addr_ok = 0; data_sram_data_ok = 0;
  endtask

  task automatic do_reset();
    resetn = 0;
    repeat (2) @(posedge clk);
    #3 resetn = 1;
    next_cycle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'b00001000, 32'h1000, 32'h4,        32'h0,
                1'b1, 1'b0, 2'd2, 4'b0000, 32'h1004, 32'h0,        4'b1000};
    vecs[1] = '{8'b00000100, 32'h2000, 32'h3,        32'h000000AB,
                1'b1, 1'b1, 2'd0, 4'b1000, 32'h2003, 32'hABABABAB, 4'b0100};
    vecs[2] = '{8'b00000010, 32'h2000, 32'h2,        32'h00001234,
                1'b1, 1'b1, 2'd1, 4'b1100, 32'h2002, 32'h12341234, 4'b0100};
    vecs[3] = '{8'b00100000, 32'h3000, 32'h1,        32'h0,
                1'b0, 1'b0, 2'd1, 4'b0000, 32'h3001, 32'h0,        4'b1011};
    vecs[4] = '{8'b00001000, 32'h3000, 32'h2,        32'h0,
                1'b0, 1'b0, 2'd2, 4'b0000, 32'h3002, 32'h0,        4'b1011};
    vecs[5] = '{8'b00000001, 32'h4000, 32'h10,       32'hDEADBEEF,
                1'b1, 1'b1, 2'd2, 4'b1111, 32'h4010, 32'hDEADBEEF, 4'b0100};
    vecs[6] = '{8'b01000000, 32'h5004, 32'hFFFFFFFF, 32'h0,
                1'b1, 1'b0, 2'd0, 4'b0000, 32'h5003, 32'h0,        4'b1000};
    vecs[7] = '{8'b00000000, 32'h10,   32'h20,       32'h77,
                1'b0, 1'b0, 2'd0, 4'b0000, 32'h30,   32'h0,        4'b0000};
    vecs[8] = '{8'b00000010, 32'h2000, 32'h3,        32'h00005678,
                1'b0, 1'b1, 2'd1, 4'b1100, 32'h2003, 32'h56785678, 4'b0111};
    vecs[9] = '{8'b00000100, 32'h2000, 32'h1,        32'h0000001C,
                1'b1, 1'b1, 2'd0, 4'b0010, 32'h2001, 32'h1C1C1C1C, 4'b0100};

    idle_inputs();
    resetn = 0;
    #3;
    chk("reset_req", data_sram_req, 1'b0);
    chk("reset_valid", es_to_ms_valid, 1'b0);
    chk("reset_allowin", es_allowin, 1'b0);
    chk("reset_discard", discard_pending, 1'b0);
    chk("reset_bus", es_to_ms_bus, 78'h0);
    chk("reset_addr", data_sram_addr, 32'h0);
    do_reset();
    chk("post_reset_allowin", es_allowin, 1'b1);

    // Decode table: capture, then check the one cycle the instruction spends here
    for (int i = 0; i < 10; i++) begin
      ds_to_es_valid = 1; ds_op = vecs[i].op; ds_base = vecs[i].base;
      ds_offset = vecs[i].off; ds_st_data = vecs[i].data;
      ds_dest = 5'(i + 3); ds_pc = 32'h1C000000 + 32'(i * 4);
      ms_allowin = 1; data_sram_addr_ok = 1;
      next_cycle();
      ds_to_es_valid = 0;
      #3;
      chk($sformatf("v%0d_req", i), data_sram_req, vecs[i].req);
      chk($sformatf("v%0d_wr", i), data_sram_wr, vecs[i].wr);
      chk($sformatf("v%0d_size", i), data_sram_size, vecs[i].size);
      chk($sformatf("v%0d_wstrb", i), data_sram_wstrb, vecs[i].wstrb);
      chk($sformatf("v%0d_addr", i), data_sram_addr, vecs[i].addr);
      chk($sformatf("v%0d_wdata", i), data_sram_wdata, vecs[i].wdata);
      chk($sformatf("v%0d_out_valid", i), es_to_ms_valid, 1'b1);
      chk($sformatf("v%0d_bus", i), es_to_ms_bus,
          {vecs[i].flags, vecs[i].op[7:3], 5'(i + 3), vecs[i].addr,
           32'h1C000000 + 32'(i * 4)});
      next_cycle();
    end
    data_sram_addr_ok = 0;
    chk("table_drained", es_to_ms_valid, 1'b0);

    // st_w stalled on addr_ok for three cycles, ms_ex rising meanwhile
    ds_to_es_valid = 1; ds_op = 8'b00000001; ds_base = 32'h4000; ds_offset = 32'h8;
    ds_st_data = 32'hCAFEF00D; ms_allowin = 1;
    next_cycle(); ds_to_es_valid = 0; #3;
    chk("wa_c1_req", data_sram_req, 1'b1);
    chk("wa_c1_valid", es_to_ms_valid, 1'b0);
    next_cycle(); ms_ex = 1; #3;
    chk("wa_c2_req", data_sram_req, 1'b1);
    chk("wa_c2_addr", data_sram_addr, 32'h4008);
    chk("wa_c2_wdata", data_sram_wdata, 32'hCAFEF00D);
    chk("wa_c2_wstrb", data_sram_wstrb, 4'hF);
    next_cycle(); #3;
    chk("wa_c3_req", data_sram_req, 1'b1);
    chk("wa_c3_addr", data_sram_addr, 32'h4008);
    next_cycle(); data_sram_addr_ok = 1; ms_allowin = 0; #3;
    chk("wa_ok_req", data_sram_req, 1'b1);
    chk("wa_ok_valid", es_to_ms_valid, 1'b1);
    next_cycle(); data_sram_addr_ok = 0; ms_ex = 0; #3;
    chk("wa_sent_req", data_sram_req, 1'b0);
    chk("wa_sent_valid", es_to_ms_valid, 1'b1);
    chk("wa_sent_allowin", es_allowin, 1'b0);
    ms_allowin = 1; #1;
    chk("wa_sent_allowin2", es_allowin, 1'b1);
    next_cycle(); #3;
    chk("wa_left_valid", es_to_ms_valid, 1'b0);

    // Flush while waiting for addr_ok leaves an orphan request
    ds_to_es_valid = 1; ds_op = 8'b00001000; ds_base = 32'h6000; ds_offset = 32'h10;
    next_cycle(); ds_to_es_valid = 0; #3;
    chk("or_req0", data_sram_req, 1'b1);
    next_cycle(); flush = 1; #3;
    chk("or_flush_req", data_sram_req, 1'b1);
    next_cycle(); flush = 0; ds_to_es_valid = 1; ds_base = 32'h7000; #3;
    chk("or_allowin", es_allowin, 1'b0);
    chk("or_req", data_sram_req, 1'b1);
    chk("or_valid", es_to_ms_valid, 1'b0);
    chk("or_discard0", discard_pending, 1'b0);
    next_cycle(); ds_to_es_valid = 0; data_sram_addr_ok = 1; #3;
    chk("or_hold_addr", data_sram_addr, 32'h6010);
    chk("or_hold_req", data_sram_req, 1'b1);
    next_cycle(); data_sram_addr_ok = 0; data_sram_data_ok = 1; #3;
    chk("or_discard1", discard_pending, 1'b1);
    chk("or_done_req", data_sram_req, 1'b0);
    chk("or_done_allowin", es_allowin, 1'b1);
    next_cycle(); data_sram_data_ok = 0; #3;
    chk("or_discard_clr", discard_pending, 1'b0);

    // Flush in SENT bumps the counter, then async reset mid-WAIT_ADDR
    ds_to_es_valid = 1; ds_op = 8'b00001000; ds_base = 32'h8000; ds_offset = 32'h0;
    data_sram_addr_ok = 1; ms_allowin = 0;
    next_cycle(); ds_to_es_valid = 0; #3;
    chk("rs_req", data_sram_req, 1'b1);
    next_cycle(); data_sram_addr_ok = 0; flush = 1; #3;
    chk("rs_sent_req", data_sram_req, 1'b0);
    next_cycle(); flush = 0; ds_to_es_valid = 1; ds_op = 8'b00000001; ds_base = 32'h9000;
    ds_offset = 32'h4; ms_allowin = 1; #3;
    chk("rs_discard", discard_pending, 1'b1);
    chk("rs_allowin", es_allowin, 1'b1);
    next_cycle(); ds_to_es_valid = 0; #3;
    chk("rs_wait_req", data_sram_req, 1'b1);
    next_cycle(); #1;
    chk("rs_wait_req2", data_sram_req, 1'b1);
    resetn = 0; #1;
    chk("rs_async_req", data_sram_req, 1'b0);
    chk("rs_async_valid", es_to_ms_valid, 1'b0);
    chk("rs_async_discard", discard_pending, 1'b0);
    chk("rs_async_allowin", es_allowin, 1'b0);
    idle_inputs();
    do_reset();
    model_reset();

    // Randomized run against the reference model
    for (int c = 0; c < 3000; c++) begin
      int unsigned r;
      int o;
      ds_to_es_valid = ($urandom_range(0, 99) < 60);
      r = $urandom_range(0, 8);
      ds_op = (r == 8) ? 8'h00 : 8'(1 << r);
      ds_base = $urandom;
      o = int'($urandom_range(0, 15)) - 8;
      ds_offset = 32'(o);
      ds_st_data = $urandom;
      ds_dest = 5'($urandom);
      ds_pc = $urandom;
      ds_ex = ($urandom_range(0, 99) < 5);
      ms_allowin = ($urandom_range(0, 99) < 70);
      ms_ex = ($urandom_range(0, 99) < 10);
      flush = ($urandom_range(0, 99) < 6);
      data_sram_addr_ok = ($urandom_range(0, 99) < 40);
      data_sram_data_ok = ($urandom_range(0, 99) < 30);
      #3;
      model_eval();
      chk("rnd_req", data_sram_req, e_req);
      chk("rnd_out_valid", es_to_ms_valid, e_ov);
      chk("rnd_allowin", es_allowin, e_allow);
      chk("rnd_discard", discard_pending, m_disc != 0);
      chk("rnd_wr", data_sram_wr, e_store);
      chk("rnd_size", data_sram_size, e_size);
      chk("rnd_wstrb", data_sram_wstrb, e_wstrb);
      chk("rnd_addr", data_sram_addr, e_addr);
      chk("rnd_wdata", data_sram_wdata, e_wdata);
      chk("rnd_bus", es_to_ms_bus, e_bus);
      @(posedge clk);
      model_step();
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
